// File: rtl/upsampler_pkg.sv
// upsampler_pkg: default geometry, derived widths and read-side state type
// for the 2x2 pixel-replicating upsampler.
package upsampler_pkg;
    localparam int IN_W    = 400;
    localparam int IN_H    = 300;
    localparam int H_TOTAL = 840;
    localparam int V_TOTAL = 640;
    localparam int DW      = 8;
    localparam int ACT_W   = 2 * IN_W;
    localparam int ACT_H   = 2 * IN_H;
    localparam int COL_AW  = $clog2(IN_W);
    localparam int RAM_AW  = $clog2(2 * IN_W);
    localparam int HCNT_W  = $clog2(H_TOTAL);
    localparam int VCNT_W  = $clog2(V_TOTAL);
    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/upsampler_line_buffer.sv
// line_buffer: two line banks in one simple dual-port RAM with a registered read.
// Bank 1 starts at word W so the RAM holds exactly 2*W words.
module line_buffer #(
    parameter int W = upsampler_pkg::IN_W,
    parameter int DW = upsampler_pkg::DW,
    localparam int CW = $clog2(W),
    localparam int AW = $clog2(2 * W)
) (
    input  logic          i_clock,
    input  logic          i_we,
    input  logic          i_wbank,
    input  logic [CW-1:0] i_wcol,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rbank,
    input  logic [CW-1:0] i_rcol,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2*W];
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    assign w_waddr = (i_wbank ? AW'(W) : '0) + AW'(i_wcol);
    assign w_raddr = (i_rbank ? AW'(W) : '0) + AW'(i_rcol);

    always_ff @(posedge i_clock) begin
        if (i_we) r_mem[w_waddr] <= i_wdata;
        o_rdata <= r_mem[w_raddr];
    end
endmodule

// File: rtl/upsampler.sv
// upsampler: buffers input lines into ping-pong banks and replays each line
// twice at double width on a free-running output raster.
module upsampler #(
    parameter int IN_W    = upsampler_pkg::IN_W,
    parameter int IN_H    = upsampler_pkg::IN_H,
    parameter int H_TOTAL = upsampler_pkg::H_TOTAL,
    parameter int V_TOTAL = upsampler_pkg::V_TOTAL,
    parameter int DW      = upsampler_pkg::DW
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic [DW-1:0] o_dataout,
    output logic          o_validout,
    output logic          o_blankingregion,
    output logic          o_frame_start,
    output logic          o_underflow
);
    import upsampler_pkg::*;
    localparam int ACT_COLS = 2 * IN_W;
    localparam int ACT_ROWS = 2 * IN_H;
    localparam int CW = $clog2(IN_W);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    state_t        r_state, w_next;
    logic          r_wbank, r_rbank;
    logic [CW-1:0] r_wcol;
    logic [1:0]    r_full;
    logic [VW-1:0] r_row;
    logic [HW-1:0] r_col;
    logic          r_bad, r_underflow;
    logic          r_act, r_zero, r_fs;
    logic [DW-1:0] w_q;
    logic [CW-1:0] w_rcol;
    logic          w_accept, w_last, w_run, w_col_end;
    logic          w_row_act, w_act, w_pair_start, w_pair_end, w_bad;

    assign o_ready      = !r_full[r_wbank];
    assign w_accept     = i_valid && o_ready;
    assign w_last       = w_accept && r_wcol == CW'(IN_W - 1);
    assign w_run        = r_state == RUN;
    assign w_col_end    = r_col == HW'(H_TOTAL - 1);
    assign w_row_act    = w_run && r_row < VW'(ACT_ROWS);
    assign w_act        = w_row_act && r_col < HW'(ACT_COLS);
    assign w_pair_start = w_row_act && !r_row[0] && r_col == '0;
    assign w_pair_end   = w_row_act && r_row[0] && w_col_end;
    // A starved line pair is decided at its first pixel and held for both rows.
    assign w_bad        = w_pair_start ? !r_full[r_rbank] : r_bad;
    assign w_rcol       = w_act ? CW'(r_col >> 1) : '0;

    always_comb w_next = (r_state == IDLE && r_full[0]) ? RUN : r_state;

    line_buffer #(.W(IN_W), .DW(DW)) u_line_buffer (
        .i_clock (i_clock),
        .i_we    (w_accept),
        .i_wbank (r_wbank),
        .i_wcol  (r_wcol),
        .i_wdata (i_data),
        .i_rbank (r_rbank),
        .i_rcol  (w_rcol),
        .o_rdata (w_q)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_wbank          <= 1'b0;
            r_rbank          <= 1'b0;
            r_wcol           <= '0;
            r_full           <= '0;
            r_row            <= '0;
            r_col            <= '0;
            r_bad            <= 1'b0;
            r_underflow      <= 1'b0;
            r_act            <= 1'b0;
            r_zero           <= 1'b0;
            r_fs             <= 1'b0;
            o_dataout        <= '0;
            o_validout       <= 1'b0;
            o_blankingregion <= 1'b1;
            o_frame_start    <= 1'b0;
            o_underflow      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_wcol <= w_last ? '0 : r_wcol + CW'(1);
            if (w_last) r_wbank <= !r_wbank;
            // Read-side clear and write-side set always hit different banks.
            if (w_pair_end && !w_bad) begin
                r_full[r_rbank] <= 1'b0;
                r_rbank         <= !r_rbank;
            end
            if (w_last) r_full[r_wbank] <= 1'b1;
            if (w_run) begin
                r_col <= w_col_end ? '0 : r_col + HW'(1);
                if (w_col_end) r_row <= r_row == VW'(V_TOTAL - 1) ? '0 : r_row + VW'(1);
            end
            r_bad <= w_bad;
            if (w_pair_start && !r_full[r_rbank]) r_underflow <= 1'b1;
            r_act            <= w_act;
            r_zero           <= w_bad;
            r_fs             <= w_run && r_row == '0 && r_col == '0;
            o_dataout        <= (r_act && !r_zero) ? w_q : '0;
            o_validout       <= r_act;
            o_blankingregion <= !r_act;
            o_frame_start    <= r_fs;
            o_underflow      <= r_underflow;
        end
    end
endmodule
